vote_capture: RTL

- Front-end ballot stage of the voting machine; feeds the candidate-select mux and tally logic.
- Synchronizes and debounces raw candidate push-buttons.
- Accepts exactly one vote per ballot session armed by the controller.
- Emits a one-cycle `vote_valid` pulse with a binary candidate index `vote_sel`.

---
 rtl/vote_capture_if.sv | 23 ++
 rtl/vote_capture.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/vote_capture_if.sv
// Ballot handshake bundle between the voting controller (master) and vote_capture (slave).
interface vote_capture_if #(
    parameter int N_CAND = 4
);
    localparam int SEL_W = $clog2(N_CAND);

    logic              ballot_en;
    logic [N_CAND-1:0] btn;
    logic              vote_valid;
    logic [SEL_W-1:0]  vote_sel;
    logic              busy;
    logic              err_multi;

    modport master (
        output ballot_en, btn,
        input  vote_valid, vote_sel, busy, err_multi
    );

    modport slave (
        input  ballot_en, btn,
        output vote_valid, vote_sel, busy, err_multi
    );
endinterface

// File: rtl/vote_capture.sv
// Ballot front end: synchronizes/debounces candidate buttons, accepts one vote per armed session.
// Optional VOTE_CAPTURE_MULTI_REJECT_EN: reject multi-button presses with an err_multi pulse.
module vote_capture #(
    parameter int N_CAND          = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input logic           clk,
    input logic           rst_n,
    vote_capture_if.slave bus
);
    localparam int SEL_W = $clog2(N_CAND);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_DEBOUNCE,
        S_WAIT_RELEASE
    } state_t;

    function automatic logic [SEL_W-1:0] to_index(input logic [N_CAND-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_CAND; i++) begin
            if (oh[i]) idx = idx | SEL_W'(i);
        end
        return idx;
    endfunction

    logic [N_CAND-1:0] r_sync1;
    logic [N_CAND-1:0] r_btn_s;
    logic              r_ballot_en_q;
    state_t            r_state;
    logic [N_CAND-1:0] r_pattern;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_vote_valid;
    logic [SEL_W-1:0]  r_vote_sel;
    logic              r_voted;
    logic              r_err_multi;

    state_t            w_state_nxt;
    logic [N_CAND-1:0] w_pattern_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_vote_valid_nxt;
    logic [SEL_W-1:0]  w_vote_sel_nxt;
    logic              w_voted_nxt;
    logic              w_err_multi_nxt;

    logic              w_arm;
    logic              w_btn_any;
    logic              w_btn_onehot;

    assign w_arm        = bus.ballot_en & ~r_ballot_en_q;
    assign w_btn_any    = |r_btn_s;
    assign w_btn_onehot = w_btn_any && ((r_btn_s & (r_btn_s - N_CAND'(1))) == '0);

`ifndef VOTE_CAPTURE_MULTI_REJECT_EN
    logic [N_CAND-1:0] w_btn_lowest;
    assign w_btn_lowest = r_btn_s & (~r_btn_s + N_CAND'(1));
`endif

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1       <= '0;
            r_btn_s       <= '0;
            r_ballot_en_q <= 1'b0;
        end else begin
            r_sync1       <= bus.btn;
            r_btn_s       <= r_sync1;
            r_ballot_en_q <= bus.ballot_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_pattern    <= '0;
            r_cnt        <= '0;
            r_vote_valid <= 1'b0;
            r_vote_sel   <= '0;
            r_voted      <= 1'b0;
            r_err_multi  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pattern    <= w_pattern_nxt;
            r_cnt        <= w_cnt_nxt;
            r_vote_valid <= w_vote_valid_nxt;
            r_vote_sel   <= w_vote_sel_nxt;
            r_voted      <= w_voted_nxt;
            r_err_multi  <= w_err_multi_nxt;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        w_state_nxt      = r_state;
        w_pattern_nxt    = r_pattern;
        w_cnt_nxt        = r_cnt;
        w_vote_valid_nxt = 1'b0;
        w_vote_sel_nxt   = r_vote_sel;
        w_voted_nxt      = r_voted;
        w_err_multi_nxt  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (w_arm) w_state_nxt = S_ARMED;
            end

            S_ARMED: begin
                if (!bus.ballot_en) begin
                    w_state_nxt = S_IDLE;
                end else if (w_btn_onehot) begin
                    w_pattern_nxt = r_btn_s;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = S_DEBOUNCE;
                end else if (w_btn_any) begin
`ifdef VOTE_CAPTURE_MULTI_REJECT_EN
                    w_err_multi_nxt = 1'b1;
                    w_voted_nxt     = 1'b0;
                    w_state_nxt     = S_WAIT_RELEASE;
`else
                    // Debounce the lowest button; the raw pattern must still settle to match it.
                    w_pattern_nxt = w_btn_lowest;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = S_DEBOUNCE;
`endif
                end
            end

            S_DEBOUNCE: begin
                // Abort is checked first so it beats a completing count on the same edge.
                if (!bus.ballot_en) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else if (r_btn_s != r_pattern) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_ARMED;
                end else if (r_cnt != CNT_LAST) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else begin
                    w_vote_valid_nxt = 1'b1;
                    w_vote_sel_nxt   = to_index(r_pattern);
                    w_voted_nxt      = 1'b1;
                    w_cnt_nxt        = '0;
                    w_state_nxt      = S_WAIT_RELEASE;
                end
            end

            S_WAIT_RELEASE: begin
                if (!w_btn_any) begin
                    if (!r_voted && bus.ballot_en) w_state_nxt = S_ARMED;
                    else                           w_state_nxt = S_IDLE;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.vote_valid = r_vote_valid;
    assign bus.vote_sel   = r_vote_sel;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.err_multi  = r_err_multi;

endmodule
